// File: rtl/pc_seq.sv
`default_nettype none
//----------------------------------------------------------------------------
// pc_seq: program-counter sequencer (fetch, issue, local branch, halt). Rev 1.0
//----------------------------------------------------------------------------
module pc_seq #(
  parameter logic [4:0] OP_JMP = 5'd20,
  parameter logic [4:0] OP_JNZ = 5'd21,
  parameter logic [4:0] OP_ZNJ = 5'd22,
  parameter logic [7:0] TMO    = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step,
  input  logic        clear,
  input  logic [22:0] op,
  input  logic        flag,
  input  logic        exec_done,
  output logic [8:0]  pc,
  output logic [22:0] ir,
  output logic        exec_start,
  output logic        halted,
  output logic        fault,
  output logic        busy,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [8:0]  r_pc, w_pc_nxt;
  logic [22:0] r_ir, w_ir_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_fault, w_fault_nxt;
  logic [7:0]  r_wait, w_wait_nxt;
  logic        r_first, w_first_nxt;
  logic        w_start;

  logic [4:0]  w_opc;
  logic        w_is_jmp, w_is_jnz, w_is_znj, w_is_branch, w_taken, w_self_loop;
  logic [8:0]  w_target, w_pc_inc;
  logic [15:0] w_cnt_sat;
  logic [7:0]  w_wait_inc;

  assign w_opc       = r_ir[22:18];
  assign w_target    = r_ir[8:0];
  assign w_is_jmp    = (w_opc == OP_JMP);
  assign w_is_jnz    = (w_opc == OP_JNZ);
  assign w_is_znj    = (w_opc == OP_ZNJ);
  assign w_is_branch = w_is_jmp | w_is_jnz | w_is_znj;
  assign w_taken     = w_is_jmp | (w_is_jnz & flag) | (w_is_znj & ~flag);
  // A jump onto itself can never make progress, so it is treated as a halt.
  assign w_self_loop = w_is_jmp & (w_target == r_pc);
  assign w_pc_inc    = r_pc + 9'd1;
  assign w_cnt_sat   = (&r_cnt) ? r_cnt : r_cnt + 16'd1;
  assign w_wait_inc  = r_wait + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= 9'd0;
      r_ir    <= 23'd0;
      r_cnt   <= 16'd0;
      r_fault <= 1'b0;
      r_wait  <= 8'd0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fault <= w_fault_nxt;
      r_wait  <= w_wait_nxt;
      r_first <= w_first_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_cnt_nxt   = r_cnt;
    w_fault_nxt = r_fault;
    w_wait_nxt  = r_wait;
    w_first_nxt = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run || step) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_ir_nxt    = op;
        w_first_nxt = 1'b1;
        w_wait_nxt  = 8'd0;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (w_is_branch) begin
          w_cnt_nxt   = w_cnt_sat;
          w_pc_nxt    = w_taken ? w_target : w_pc_inc;
          w_state_nxt = w_self_loop ? S_HALT : (run ? S_FETCH : S_IDLE);
        end else begin
          w_start = r_first;
          if (exec_done) begin
            w_cnt_nxt   = w_cnt_sat;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = run ? S_FETCH : S_IDLE;
          end else if (w_wait_inc == TMO) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = S_HALT;
          end else begin
            w_wait_nxt = w_wait_inc;
          end
        end
      end
      S_HALT: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = 9'd0;
          w_fault_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign pc          = r_pc;
  assign ir          = r_ir;
  assign exec_start  = w_start;
  assign halted      = (r_state == S_HALT);
  assign fault       = r_fault;
  assign busy        = (r_state == S_FETCH) || (r_state == S_EXEC);
  assign instr_count = r_cnt;

endmodule
`default_nettype wire
